// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Copies `length` consecutive words from src_addr to dst_addr in a single-port
// data memory. Words are copied one at a time in ascending order: one read
// cycle, then one write cycle. For overlapping regions the result is therefore
// exactly that of a forward word-by-word copy.
//
// Ports
//   clk            : clock; all state changes on the rising edge
//   rst_n          : asynchronous active-low reset
//   start          : begin a copy; only looked at while idle
//   src_addr       : first source word address (captured on accepted start)
//   dst_addr       : first destination word address (captured on accepted start)
//   length         : number of words to copy (0 completes without memory access)
//   busy           : high from the accepted start until the done pulse ends
//   done           : one-cycle completion pulse
//   mem_address    : word address to the data memory
//   mem_write_data : write data to the data memory
//   mem_read       : read enable to the data memory
//   mem_write      : write enable; the memory commits on the rising edge
//   mem_read_data  : combinational read data for the current mem_address
module mem_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  index;
    logic [LEN_W-1:0]  index_inc;
    logic [DATA_W-1:0] buffer;

    // index never exceeds len_reg-1, so index+1 cannot overflow LEN_W bits.
    assign index_inc = index + LEN_W'(1);

    // The buffer register feeds the write port directly; the write enable
    // qualifies it, so its value outside WR is irrelevant.
    assign mem_write_data = buffer;

    // All memory-side outputs are registered: each is loaded with the value
    // it must show in the next state, so nothing from start or the address
    // inputs reaches an output combinationally. Address sums wrap modulo
    // 2^ADDR_W by virtue of the register width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            src_reg     <= '0;
            dst_reg     <= '0;
            len_reg     <= '0;
            index       <= '0;
            buffer      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            src_reg     <= src_addr;
                            dst_reg     <= dst_addr;
                            len_reg     <= length;
                            index       <= '0;
                            mem_read    <= 1'b1;
                            mem_address <= src_addr;
                            state       <= RD;
                        end else begin
                            // Empty copy: straight to completion, no access.
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                RD: begin
                    buffer      <= mem_read_data;
                    mem_read    <= 1'b0;
                    mem_write   <= 1'b1;
                    mem_address <= dst_reg + ADDR_W'(index);
                    state       <= WR;
                end

                WR: begin
                    mem_write <= 1'b0;
                    index     <= index_inc;
                    if (index == len_reg - LEN_W'(1)) begin
                        done        <= 1'b1;
                        mem_address <= '0;
                        state       <= DONE;
                    end else begin
                        mem_read    <= 1'b1;
                        mem_address <= src_reg + ADDR_W'(index_inc);
                        state       <= RD;
                    end
                end

                DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    mem_address <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a vector table of copies with
// expected latency and write counts, hand-written sequences for busy
// protection, held start and mid-copy reset, and random copies checked
// against a forward-copy reference memory.
module tb_mem_copy_engine;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_read_data;

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT and the reference image it must end up matching.
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    assign mem_read_data = mem[mem_address];

    int errors = 0;
    int checks = 0;
    int n_wr, n_rd, n_done;
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] wr_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_write) begin
                mem[mem_address] = mem_write_data;
                n_wr++;
                wr_q.push_back(mem_address);
            end
            if (mem_read) begin
                n_rd++;
                rd_q.push_back(mem_address);
            end
            if (done) n_done++;
        end
    end

    // Read and write enables must never coincide.
    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            checks++;
            errors++;
            $display("FAIL rw_exclusive: got read=1 write=1 required not both");
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Forward word-by-word copy with 16-bit wrapping addresses.
    task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] sa, da;
            sa = s + AW'(i);
            da = d + AW'(i);
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic check_mem(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < 65536; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        if (bad != 0) $display("note %s: first differing address %0h", name, first);
        chk({name, " mem_image_diffs"}, 64'(bad), 64'd0);
    endtask

    task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic run_copy(input string name, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input bit poke, input int exp_cycles,
                            input int exp_writes, input bit no_wait);
        int cycles;
        bit got_done;
        bit busy_ok;
        int bad;
        if (!no_wait) @(negedge clk);
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        length = n;
        n_wr = 0;
        n_rd = 0;
        n_done = 0;
        rd_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the inputs; the copy in flight must not notice.
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length = LW'($urandom);
        ref_copy(s, d, int'(n));
        cycles = 0;
        got_done = 1'b0;
        busy_ok = 1'b1;
        while (cycles < 2 * int'(n) + 20 && !got_done) begin
            @(negedge clk);
            cycles++;
            if (!busy) busy_ok = 1'b0;
            if (poke && cycles == 3) begin
                start = 1'b1;
                src_addr = 16'h0ABC;
                dst_addr = 16'h0DEF;
                length = 8'd7;
            end
            if (poke && cycles == 4) start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                chk({name, " enables_in_done"}, {62'd0, mem_read, mem_write}, 64'd0);
            end
        end
        chk({name, " done_cycle"}, 64'(cycles), 64'(exp_cycles));
        chk({name, " busy_throughout"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
        chk({name, " writes"}, 64'(n_wr), 64'(exp_writes));
        chk({name, " reads"}, 64'(n_rd), 64'(exp_writes));
        chk({name, " done_pulses"}, 64'(n_done), 64'd1);
        bad = 0;
        for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== d + AW'(i)) bad++;
        for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] !== s + AW'(i)) bad++;
        chk({name, " addr_sequence_errs"}, 64'(bad), 64'd0);
        check_mem(name);
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        bit            poke;
        int            exp_cycles;
        int            exp_writes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cycles;
        bit got_done;

        vecs[0] = '{"basic",    16'h0010, 16'h0040, 8'd4,   1'b0, 9,   4};
        vecs[1] = '{"zero_len", 16'h0100, 16'h0200, 8'd0,   1'b0, 1,   0};
        vecs[2] = '{"wrap",     16'hFFFE, 16'h0020, 8'd3,   1'b0, 7,   3};
        vecs[3] = '{"overlap",  16'h0000, 16'h0001, 8'd3,   1'b0, 7,   3};
        vecs[4] = '{"busy_ign", 16'h0300, 16'h0380, 8'd4,   1'b1, 9,   4};
        vecs[5] = '{"max_len",  16'h1000, 16'h2000, 8'd255, 1'b0, 511, 255};

        for (int a = 0; a < 65536; a++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            mem[a] = v;
            ref_mem[a] = v;
        end
        for (int i = 0; i < 4; i++) set_word(AW'(16'h10 + i), DW'(16'hA0 + i));
        for (int i = 0; i < 4; i++) set_word(AW'(i), DW'(i + 1));

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, mem_read, mem_write, mem_address, mem_write_data}, 64'd0);
        rst_n = 1'b1;

        // Table of copies
        for (int v = 0; v < 6; v++) begin
            run_copy(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].poke,
                     vecs[v].exp_cycles, vecs[v].exp_writes, 1'b0);
        end
        chk("basic_dst_words", {mem[16'h40], mem[16'h41], mem[16'h42], mem[16'h43]},
            {16'hA0, 16'hA1, 16'hA2, 16'hA3});
        chk("overlap_words", {mem[0], mem[1], mem[2], mem[3]},
            {16'd1, 16'd1, 16'd1, 16'd1});

        // Start held high: a second copy begins on the first idle cycle after done
        @(negedge clk);
        start = 1'b1;
        src_addr = 16'h0500;
        dst_addr = 16'h0600;
        length = 8'd2;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 5) chk("held_start done_c5", {63'd0, done}, 64'd1);
            if (c == 6) chk("held_start idle_c6", {63'd0, busy}, 64'd0);
            if (c == 7) chk("held_start restart_c7", {46'd0, busy, mem_read, mem_address}, {46'd0, 1'b1, 1'b1, 16'h0500});
        end
        start = 1'b0;
        got_done = 1'b0;
        cycles = 0;
        while (cycles < 20 && !got_done) begin
            @(negedge clk);
            cycles++;
            if (done) got_done = 1'b1;
        end
        chk("held_start second_done", 64'(got_done), 64'd1);
        ref_copy(16'h0500, 16'h0600, 2);
        ref_copy(16'h0500, 16'h0600, 2);
        @(negedge clk);
        check_mem("held_start");

        // Reset during the write of word 2 of 4
        @(negedge clk);
        start = 1'b1;
        src_addr = 16'h0700;
        dst_addr = 16'h0780;
        length = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        chk("midreset in_wr2", {47'd0, mem_write, mem_address}, {47'd0, 1'b1, 16'h0782});
        rst_n = 1'b0;
        #1;
        chk("midreset outputs_zero", {busy, done, mem_read, mem_write, mem_address, mem_write_data}, 64'd0);
        ref_copy(16'h0700, 16'h0780, 2);
        @(negedge clk);
        check_mem("midreset");
        rst_n = 1'b1;
        run_copy("after_reset", 16'h0700, 16'h0780, 8'd4, 1'b0, 9, 4, 1'b1);

        // Random copies against the reference image
        for (int r = 0; r < 20; r++) begin
            logic [AW-1:0] s, d;
            logic [LW-1:0] n;
            s = AW'($urandom);
            d = AW'($urandom);
            if (r % 3 == 0) d = s + AW'($urandom_range(0, 6));
            n = LW'($urandom_range(0, 24));
            run_copy($sformatf("rand%0d", r), s, d, n, 1'b0, 2 * int'(n) + 1, int'(n), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
